alu_control_seq: RTL and testbench

- Registered, parametrised successor to the combinational ALU control decoder in the multicycle MIPS core.
- Accepts an instruction's Opcode/Funccode on a Start pulse and registers the AluControl code and AluSrc2Sel.
- Owns an iterative multiply/divide engine for MULT/MULTU/DIV/DIVU, with HI/LO result registers and a Busy/Done handshake.
- Sits between the main control FSM (which issues Start and stalls on Busy) and the datapath ALU / HI-LO write path.

---
 rtl/alu_control_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_control_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered ALU control decoder with an iterative multiply/divide
// engine (shift-add / restoring divide) feeding the HI/LO registers.
module alu_control_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             Start,
   input  logic [5:0]       Opcode,
   input  logic [5:0]       Funccode,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic [3:0]       AluControl,
   output logic             AluSrc2Sel,
   output logic             Illegal,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);
   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
   state_t state_q, state_d;
   logic [3:0] ctl_q, ctl_d, dec;
   logic src2_q, src2_d, ill_q, ill_d, busy_q, busy_d, done_q, done_d, dz_q, dz_d;
   logic is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*WIDTH:0] acc_q, acc_d, step;
   logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b;
   logic [WIDTH:0] sum, sh;
   logic [2*WIDTH-1:0] prod;
   logic muldiv, sgn, a_neg, b_neg, accept;

   always_comb begin
      dec = 4'b1111;
      case (Opcode)
         6'b000000:
            case (Funccode)
               6'b000000, 6'b000100: dec = 4'b0011;
               6'b000010, 6'b000110: dec = 4'b1100;
               6'b000011, 6'b000111: dec = 4'b0101;
               6'b001000, 6'b001001, 6'b010001, 6'b010011, 6'b100001: dec = 4'b0010;
               6'b011000: dec = 4'b1010;
               6'b011001: dec = 4'b1011;
               6'b011010: dec = 4'b1000;
               6'b011011: dec = 4'b1001;
               6'b100011: dec = 4'b0110;
               6'b100100: dec = 4'b0000;
               6'b100101: dec = 4'b0001;
               6'b100110: dec = 4'b1101;
               6'b101010: dec = 4'b0111;
               6'b101011: dec = 4'b0100;
               default:   dec = 4'b1111;
            endcase
         6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: dec = 4'b0110;
         6'b001001: dec = 4'b0010;
         6'b001010: dec = 4'b0111;
         6'b001011: dec = 4'b0100;
         6'b001100: dec = 4'b0000;
         6'b001101: dec = 4'b0001;
         6'b001110: dec = 4'b1101;
         6'b001111: dec = 4'b1110;
         6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
         6'b101000, 6'b101001, 6'b101010, 6'b101011, 6'b101110: dec = 4'b0010;
         default: dec = 4'b1111;
      endcase
   end

   // Codes 10xx are the mul/div ops: bit1 clear = divide, bit0 clear = signed.
   assign muldiv = dec[3] && !dec[2];
   assign sgn    = !dec[0];
   assign accept = state_q == IDLE && Start;
   assign a_neg  = sgn && OpA[WIDTH-1];
   assign b_neg  = sgn && OpB[WIDTH-1];
   assign mag_a  = a_neg ? -OpA : OpA;
   assign mag_b  = b_neg ? -OpB : OpB;

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
   assign sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, b_q} : '0);
   assign sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign step = is_div_q ? (sh >= {1'b0, b_q} ? {sh - {1'b0, b_q}, acc_q[WIDTH-2:0], 1'b1}
                                               : {sh, acc_q[WIDTH-2:0], 1'b0})
                          : {1'b0, sum, acc_q[WIDTH-1:1]};
   assign prod = qneg_q ? -step[2*WIDTH-1:0] : step[2*WIDTH-1:0];

   always_comb begin
      state_d  = state_q;
      ctl_d    = ctl_q;
      src2_d   = src2_q;
      ill_d    = ill_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dz_d     = dz_q;
      is_div_d = is_div_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      if (accept) begin
         ctl_d  = dec;
         src2_d = Opcode[5:3] == 3'b001 || Opcode[5] || (Opcode == 6'd0 && Funccode[5:2] == 4'd0);
         ill_d  = dec == 4'b1111;
         dz_d   = 1'b0;
         if (!muldiv) begin
            done_d = 1'b1;
         end else if (!dec[1] && OpB == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
            dz_d    = 1'b1;
            hi_d    = OpA;
            lo_d    = '1;
         end else begin
            state_d  = RUN;
            busy_d   = 1'b1;
            cnt_d    = CNT_W'(WIDTH);
            is_div_d = !dec[1];
            qneg_d   = a_neg ^ b_neg;
            rneg_d   = a_neg;
            b_d      = dec[1] ? mag_a : mag_b;
            acc_d    = {{(WIDTH+1){1'b0}}, dec[1] ? mag_b : mag_a};
         end
      end else if (state_q == RUN) begin
         acc_d = step;
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hi_d    = is_div_q ? (rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH])
                               : prod[2*WIDTH-1:WIDTH];
            lo_d    = is_div_q ? (qneg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0])
                               : prod[WIDTH-1:0];
         end
      end else if (state_q == FINISH) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         ctl_q    <= 4'b1111;
         src2_q   <= 1'b0;
         ill_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         is_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         ctl_q    <= ctl_d;
         src2_q   <= src2_d;
         ill_q    <= ill_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
         is_div_q <= is_div_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign AluControl = ctl_q;
   assign AluSrc2Sel = src2_q;
   assign Illegal    = ill_q;
   assign Busy       = busy_q;
   assign Done       = done_q;
   assign DivZero    = dz_q;
   assign Hi         = hi_q;
   assign Lo         = lo_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: randomized bench for alu_control_seq against a mnemonic-table
// decode model and 64-bit arithmetic reference for mul/div results.
module tb_alu_control_seq;
   localparam int W = 32;
   logic clk = 1'b0, reset_n = 1'b0, Start = 1'b0;
   logic [5:0] Opcode = '0, Funccode = '0;
   logic [W-1:0] OpA = '0, OpB = '0;
   logic [3:0] AluControl;
   logic AluSrc2Sel, Illegal, Busy, Done, DivZero;
   logic [W-1:0] Hi, Lo;
   int n_checks = 0, n_fail = 0;
   logic [3:0] e_ctl = 4'hF;
   logic e_src2 = 1'b0, e_ill = 1'b0, e_dz = 1'b0;
   logic [W-1:0] e_hi = '0, e_lo = '0;

   typedef struct {logic [5:0] op; logic [5:0] fn; logic [3:0] ctl;} enc_t;
   enc_t tbl[$];

   alu_control_seq dut (
      .clk(clk), .reset_n(reset_n), .Start(Start), .Opcode(Opcode), .Funccode(Funccode),
      .OpA(OpA), .OpB(OpB), .AluControl(AluControl), .AluSrc2Sel(AluSrc2Sel),
      .Illegal(Illegal), .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic add(input int op, input int fn, input int c);
      enc_t e;
      e.op = 6'(op);
      e.fn = 6'(fn);
      e.ctl = 4'(c);
      tbl.push_back(e);
   endtask

   // R-type entries match on funct; every other opcode matches on opcode alone.
   function automatic logic [3:0] ref_ctl(input logic [5:0] op, input logic [5:0] fn);
      foreach (tbl[i])
         if (tbl[i].op == op && (op != 6'd0 || tbl[i].fn == fn)) return tbl[i].ctl;
      return 4'hF;
   endfunction

   function automatic logic ref_src2(input logic [5:0] op, input logic [5:0] fn);
      return (op >= 8 && op < 16) || op >= 32 || (op == 0 && fn < 4);
   endfunction

   task automatic ref_muldiv(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
      longint sa, sb, p, q, r;
      logic [63:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = (c == 4'b1000 || c == 4'b1001) && b == '0;
      if (dz) begin
         h = a;
         l = '1;
      end else if (c == 4'b1010) begin
         p = sa * sb;
         h = p[63:32];
         l = p[31:0];
      end else if (c == 4'b1011) begin
         u = {32'd0, a} * {32'd0, b};
         h = u[63:32];
         l = u[31:0];
      end else if (c == 4'b1000) begin
         q = sa / sb;
         r = sa % sb;
         h = r[31:0];
         l = q[31:0];
      end else begin
         h = a % b;
         l = a / b;
      end
   endtask

   // Issues one instruction from a negedge; returns at a negedge with the FSM idle.
   task automatic do_op(input logic [5:0] op, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke);
      logic [3:0] c;
      logic [W-1:0] h, l;
      logic dz;
      bit md;
      int busy_n, done_at;
      c = ref_ctl(op, fn);
      md = c inside {4'b1000, 4'b1001, 4'b1010, 4'b1011};
      h = e_hi;
      l = e_lo;
      dz = 1'b0;
      if (md) ref_muldiv(c, a, b, h, l, dz);
      Opcode = op; Funccode = fn; OpA = a; OpB = b; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      Opcode = 6'($urandom); Funccode = 6'($urandom); OpA = $urandom; OpB = $urandom;
      e_ctl = c; e_src2 = ref_src2(op, fn); e_ill = c == 4'hF; e_dz = dz;
      check("ctl", AluControl, e_ctl);
      check("src2", AluSrc2Sel, e_src2);
      check("illegal", Illegal, e_ill);
      check("divzero_start", DivZero, e_dz);
      check("busy_start", Busy, md && !dz);
      if (!md) begin
         check("done_1cyc", Done, 1);
         check("hi_hold", Hi, e_hi);
         check("lo_hold", Lo, e_lo);
         @(negedge clk);
         check("done_pulse", Done, 0);
         return;
      end
      busy_n = 0;
      done_at = 0;
      for (int cyc = 1; cyc <= W + 4; cyc++) begin
         if (Busy) busy_n++;
         if (Done) begin
            done_at = cyc;
            break;
         end
         if (poke && cyc == 10) begin
            Opcode = 6'd0; Funccode = 6'b100110; Start = 1'b1;
         end
         @(negedge clk);
         Start = 1'b0;
      end
      check("done_latency", done_at, dz ? 1 : W + 1);
      check("busy_cycles", busy_n, dz ? 0 : W);
      check("ctl_hold_run", AluControl, e_ctl);
      check("busy_finish", Busy, 0);
      check("hi", Hi, h);
      check("lo", Lo, l);
      check("divzero", DivZero, dz);
      e_hi = h;
      e_lo = l;
      if (poke) begin
         Opcode = 6'd0; Funccode = 6'b100001; Start = 1'b1;
      end
      @(negedge clk);
      Start = 1'b0;
      check("done_end", Done, 0);
      check("ctl_hold_finish", AluControl, e_ctl);
      check("hi_hold_finish", Hi, e_hi);
   endtask

   initial begin
      logic [5:0] op, fn;
      logic [W-1:0] a, b;
      enc_t e;
      add(0, 0, 3); add(0, 4, 3); add(0, 2, 12); add(0, 6, 12); add(0, 3, 5); add(0, 7, 5);
      add(0, 8, 2); add(0, 9, 2); add(0, 17, 2); add(0, 19, 2); add(0, 33, 2); add(0, 35, 6);
      add(0, 24, 10); add(0, 25, 11); add(0, 26, 8); add(0, 27, 9);
      add(0, 36, 0); add(0, 37, 1); add(0, 38, 13); add(0, 42, 7); add(0, 43, 4);
      add(1, 0, 6); add(4, 0, 6); add(5, 0, 6); add(6, 0, 6); add(7, 0, 6);
      add(9, 0, 2); add(10, 0, 7); add(11, 0, 4); add(12, 0, 0); add(13, 0, 1);
      add(14, 0, 13); add(15, 0, 14);
      for (int i = 32; i <= 38; i++) add(i, 0, 2);
      add(40, 0, 2); add(41, 0, 2); add(42, 0, 2); add(43, 0, 2); add(46, 0, 2);
      repeat (2) @(negedge clk);
      check("rst_ctl", AluControl, 4'hF);
      check("rst_src2", AluSrc2Sel, 0);
      check("rst_illegal", Illegal, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_divzero", DivZero, 0);
      check("rst_hi", Hi, 0);
      check("rst_lo", Lo, 0);
      reset_n = 1'b1;
      @(negedge clk);
      do_op(6'd0, 6'b100001, $urandom, $urandom, 1'b0);
      check("addu_ctl", AluControl, 4'b0010);
      do_op(6'd0, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      check("multu_hi", Hi, 32'hFFFFFFFE);
      check("multu_lo", Lo, 32'h00000001);
      do_op(6'd0, 6'b011010, 32'hFFFFFFF9, 32'd2, 1'b0);
      check("div_hi", Hi, 32'hFFFFFFFF);
      check("div_lo", Lo, 32'hFFFFFFFD);
      do_op(6'd0, 6'b011011, 32'h1234, 32'd0, 1'b0);
      check("divz_hi", Hi, 32'h00001234);
      check("divz_lo", Lo, 32'hFFFFFFFF);
      do_op(6'b001001, 6'($urandom), $urandom, $urandom, 1'b0);
      check("addiu_divzero_clr", DivZero, 0);
      do_op(6'd0, 6'b011000, 32'd3, -32'd5, 1'b1);
      check("mult_hi", Hi, 32'hFFFFFFFF);
      check("mult_lo", Lo, 32'hFFFFFFF1);
      do_op(6'd0, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            op = 6'($urandom);
            fn = 6'($urandom);
         end else begin
            e = tbl[$urandom_range(0, tbl.size() - 1)];
            op = e.op;
            fn = e.op == 6'd0 ? e.fn : 6'($urandom);
         end
         a = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 300)) : $urandom;
         b = $urandom_range(0, 5) == 0 ? '0 : ($urandom_range(0, 2) == 0 ? -W'($urandom_range(1, 9)) : $urandom);
         do_op(op, fn, a, b, 1'($urandom));
      end
      do_op(6'd0, 6'b011001, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      Opcode = 6'd0; Funccode = 6'b011011; OpA = 32'hDEADBEEF; OpB = 32'd7; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (14) @(negedge clk);
      check("pre_rst_busy", Busy, 1);
      reset_n = 1'b0;
      #1;
      e_ctl = 4'hF; e_src2 = 1'b0; e_ill = 1'b0; e_dz = 1'b0; e_hi = '0; e_lo = '0;
      check("mid_rst_busy", Busy, 0);
      check("mid_rst_hi", Hi, 0);
      check("mid_rst_lo", Lo, 0);
      check("mid_rst_ctl", AluControl, 4'hF);
      check("mid_rst_done", Done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_done", Done, 0);
      check("post_rst_busy", Busy, 0);
      do_op(6'b111111, 6'($urandom), $urandom, $urandom, 1'b0);
      check("illegal_op", Illegal, 1);
      check("illegal_ctl", AluControl, 4'hF);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
